// File: rtl/line_follow_pkg.sv
// Shared types for the line-follow drive controller: FSM states, steering
// classes and H-bridge direction codes.
package line_follow_pkg;

    typedef enum logic [2:0] {
        ST_LOST     = 3'd0,
        ST_FOLLOW   = 3'd1,
        ST_JUNCTION = 3'd2,
        ST_BLOCKED  = 3'd3,
        ST_RESUME   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_FWD,
        CLS_LEFT,
        CLS_RIGHT,
        CLS_JUNC
    } cls_t;

    localparam logic [3:0] FWD   = 4'b0110;
    localparam logic [3:0] LEFT  = 4'b1010;
    localparam logic [3:0] RIGHT = 4'b0101;
    localparam logic [3:0] STOP  = 4'b0000;

    function automatic logic [2:0] state_code(input state_t s);
        return 3'(s);
    endfunction

    // Steering classes map to a direction; NONE/JUNC fall back to the held one.
    function automatic logic [3:0] cls_dir(input cls_t c, input logic [3:0] last);
        case (c)
            CLS_FWD:   return FWD;
            CLS_LEFT:  return LEFT;
            CLS_RIGHT: return RIGHT;
            default:   return last;
        endcase
    endfunction

endpackage

// File: rtl/line_follow_ctrl_sense_filter.sv
// Two-flop synchroniser followed by a consecutive-sample debounce; the
// filtered output only moves after DEB_CYC identical synchronised samples.
module sense_filter #(
    parameter int   DEB_CYC = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            filt <= RST_VAL;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 != filt) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    filt <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-following drive controller: sensor filtering, steering FSM and motor
// enables. Define LINE_FOLLOW_PWM_EN to PWM-modulate motor_en by duty.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int               N_SENS     = 3,
    parameter int               DEB_CYC    = 4,
    parameter int               JUNC_CYC   = 16,
    parameter int               LOST_CYC   = 32,
    parameter int               RESUME_CYC = 8,
    parameter int               PWM_W      = 8,
    parameter logic [PWM_W-1:0] BASE_DUTY  = 8'd200,
    parameter logic [PWM_W-1:0] TURN_DUTY  = 8'd140
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SENS-1:0] induct,
    input  logic              proxim,
    output logic [3:0]        motor_in,
    output logic [1:0]        motor_en,
    output logic [2:0]        state_o
);
    localparam int C       = (N_SENS - 1) / 2;
    localparam int MAX_A   = (LOST_CYC > JUNC_CYC) ? LOST_CYC : JUNC_CYC;
    localparam int MAX_CYC = (MAX_A > RESUME_CYC) ? MAX_A : RESUME_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [N_SENS-1:0] ind_f;
    logic              prox_f;

    for (genvar i = 0; i < N_SENS; i++) begin : g_induct
        sense_filter #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b1)) u_filt (
            .clk(clk), .rst_n(rst_n), .raw(induct[i]), .filt(ind_f[i])
        );
    end

    sense_filter #(.DEB_CYC(DEB_CYC), .RST_VAL(1'b0)) u_prox (
        .clk(clk), .rst_n(rst_n), .raw(proxim), .filt(prox_f)
    );

    logic [N_SENS-1:0] on;
    int                l_cnt;
    int                r_cnt;
    cls_t              cls;

    assign on = ~ind_f;

    always_comb begin
        l_cnt = 0;
        r_cnt = 0;
        for (int i = 0; i < C; i++) r_cnt += int'(on[i]);
        for (int i = C + 1; i < N_SENS; i++) l_cnt += int'(on[i]);
        if (&on)             cls = CLS_JUNC;
        else if (on == '0)   cls = CLS_NONE;
        else if (l_cnt > r_cnt) cls = CLS_LEFT;
        else if (r_cnt > l_cnt) cls = CLS_RIGHT;
        else                 cls = CLS_FWD;
    end

    logic [1:0] en_base;
    logic [1:0] en_turn;

`ifdef LINE_FOLLOW_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign en_base = {2{pwm_cnt < BASE_DUTY}};
    assign en_turn = {2{pwm_cnt < TURN_DUTY}};
`else
    logic unused_duty;
    assign unused_duty = ^{BASE_DUTY, TURN_DUTY};
    assign en_base = 2'b11;
    assign en_turn = 2'b11;
`endif

    state_t           state;
    logic [3:0]       last_dir;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       follow_dir;
    logic [1:0]       follow_en;
    logic [1:0]       last_en;
    logic [CNT_W-1:0] cnt_inc;

    assign follow_dir = cls_dir(cls, last_dir);
    assign follow_en  = (follow_dir == FWD) ? en_base : en_turn;
    assign last_en    = (last_dir == FWD) ? en_base : en_turn;
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign state_o    = state_code(state);

    // Obstacle overrides everything; otherwise each state sets the outputs
    // for the state it is moving into on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_LOST;
            motor_in <= STOP;
            motor_en <= 2'b00;
            last_dir <= FWD;
            cnt      <= '0;
        end else if (prox_f) begin
            state    <= ST_BLOCKED;
            motor_in <= last_dir;
            motor_en <= 2'b00;
            cnt      <= '0;
        end else begin
            case (state)
                ST_LOST: begin
                    cnt <= '0;
                    if (cls != CLS_NONE) begin
                        state    <= ST_FOLLOW;
                        motor_in <= follow_dir;
                        motor_en <= follow_en;
                    end else begin
                        motor_in <= STOP;
                        motor_en <= 2'b00;
                    end
                end
                ST_FOLLOW: begin
                    if (cls == CLS_NONE) begin
                        if (cnt == CNT_W'(LOST_CYC - 1)) begin
                            state    <= ST_LOST;
                            motor_in <= STOP;
                            motor_en <= 2'b00;
                            cnt      <= '0;
                        end else begin
                            cnt      <= cnt_inc;
                            motor_in <= last_dir;
                            motor_en <= last_en;
                        end
                    end else if (cls == CLS_JUNC) begin
                        state    <= ST_JUNCTION;
                        motor_in <= last_dir;
                        motor_en <= en_base;
                        cnt      <= '0;
                    end else begin
                        cnt      <= '0;
                        last_dir <= follow_dir;
                        motor_in <= follow_dir;
                        motor_en <= follow_en;
                    end
                end
                ST_JUNCTION: begin
                    if (cnt == CNT_W'(JUNC_CYC - 1)) begin
                        state    <= ST_FOLLOW;
                        motor_in <= follow_dir;
                        motor_en <= follow_en;
                        cnt      <= '0;
                    end else begin
                        cnt      <= cnt_inc;
                        motor_in <= last_dir;
                        motor_en <= en_base;
                    end
                end
                ST_BLOCKED: begin
                    state    <= ST_RESUME;
                    motor_in <= last_dir;
                    motor_en <= 2'b00;
                    cnt      <= '0;
                end
                ST_RESUME: begin
                    if (cnt == CNT_W'(RESUME_CYC - 1)) begin
                        state    <= ST_FOLLOW;
                        motor_in <= follow_dir;
                        motor_en <= follow_en;
                        cnt      <= '0;
                    end else begin
                        cnt      <= cnt_inc;
                        motor_in <= last_dir;
                        motor_en <= 2'b00;
                    end
                end
                default: begin
                    state    <= ST_LOST;
                    motor_in <= STOP;
                    motor_en <= 2'b00;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule
